// File: rtl/dcache_ecc_scrubber_pkg.sv
// Shared types and helpers for the data-cache ECC scrub sequencer.
package dcache_ecc_scrubber_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_FIX,
    S_VERIFY
  } scrub_state_e;

  localparam int unsigned ScrubDefaultInterval = 64;
  localparam int unsigned ScrubCntWidth        = 16;

  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/dcache_ecc_scrubber_lzc.sv
// Lowest-set-bit selector: isolates the lowest pending way as a one-hot mask.
module dcache_ecc_scrubber_lzc #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] vec,
  output logic [Width-1:0] onehot
);

  assign onehot = vec & (~vec + Width'(1));

endmodule

// File: rtl/dcache_ecc_scrubber.sv
// Background ECC scrubber: reads every set at lowest priority, rewrites ways
// with correctable errors, re-reads to verify, and counts/flags events.
module dcache_ecc_scrubber
  import dcache_ecc_scrubber_pkg::*;
#(
  parameter  int unsigned NumIdx        = 256,
  parameter  int unsigned NumWays       = 8,
  parameter  int unsigned IntervalWidth = 16,
  parameter  int unsigned CntWidth      = ScrubCntWidth,
  localparam int unsigned IdxWidth      = (NumIdx > 1) ? $clog2(NumIdx) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic                     busy_i,
  output logic [NumWays-1:0]       req_o,
  output logic                     we_o,
  output logic [IdxWidth-1:0]      idx_o,
  input  logic                     gnt_i,
  input  logic [NumWays-1:0]       ce_i,
  input  logic [NumWays-1:0]       ue_i,
  output logic                     capture_o,
  output logic [CntWidth-1:0]      ce_cnt_o,
  output logic [CntWidth-1:0]      ue_cnt_o,
  output logic                     ue_irq_o,
  output logic [IdxWidth-1:0]      ue_idx_o,
  output logic                     pass_done_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIdx - 1);

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [7:0] b);
    logic [CntWidth+8:0] s;
    s = {9'd0, a} + {{(CntWidth+1){1'b0}}, b};
    return (s > {9'd0, {CntWidth{1'b1}}}) ? '1 : s[CntWidth-1:0];
  endfunction

  scrub_state_e              state_q, state_d;
  logic [IdxWidth-1:0]       idx_q, idx_d, ue_idx_q, ue_idx_d;
  logic [IntervalWidth-1:0]  cnt_q, cnt_d;
  logic [NumWays-1:0]        pend_q, pend_d, ue_seen_q, ue_seen_d;
  logic                      verifying_q, verifying_d, wr_phase_q, wr_phase_d;
  logic [CntWidth-1:0]       ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
  logic                      ue_irq_q, ue_irq_d, pass_done_q, pass_done_d;
  logic                      advance;
  logic [NumWays-1:0]        ue_new, ce_good, lzc_vec, lowest, pend_rest;

  // UE on a way overrides CE; a UE already reported in this step is not recounted.
  assign ue_new    = ue_i & ~ue_seen_q;
  assign ce_good   = ce_i & ~(ue_i | ue_seen_q);
  assign lzc_vec   = (state_q == S_CHECK) ? ce_good : pend_q;
  assign pend_rest = pend_q & ~lowest;

  dcache_ecc_scrubber_lzc #(.Width(NumWays)) u_lzc (
    .vec    (lzc_vec),
    .onehot (lowest)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    ue_seen_d   = ue_seen_q;
    verifying_d = verifying_q;
    wr_phase_d  = wr_phase_q;
    ce_cnt_d    = ce_cnt_q;
    ue_cnt_d    = ue_cnt_q;
    ue_idx_d    = ue_idx_q;
    ue_irq_d    = 1'b0;
    pass_done_d = 1'b0;
    req_o       = '0;
    we_o        = 1'b0;
    capture_o   = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_WAIT;
          cnt_d   = interval_i;
        end
      end
      S_WAIT: begin
        if (!en_i) state_d = S_IDLE;
        else if (cnt_q <= IntervalWidth'(1)) state_d = S_READ;
        else cnt_d = cnt_q - IntervalWidth'(1);
      end
      S_READ, S_VERIFY: begin
        req_o = busy_i ? '0 : '1;
        if (gnt_i && !busy_i) begin
          state_d     = S_CHECK;
          verifying_d = (state_q == S_VERIFY);
        end else if (state_q == S_READ && !en_i) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        ue_seen_d = ue_seen_q | ue_i;
        if (|ue_new) begin
          ue_cnt_d = sat_add(ue_cnt_q, popcount(64'(ue_new)));
          ue_irq_d = 1'b1;
          ue_idx_d = idx_q;
        end
        if (verifying_q) begin
          // Persistent CE after a rewrite is a stuck bit: count it, do not refix.
          ce_cnt_d = sat_add(ce_cnt_q, popcount(64'(ce_good)));
          advance  = 1'b1;
        end else if (|ce_good) begin
          if (busy_i) begin
            state_d = S_READ;
          end else begin
            req_o      = lowest;
            capture_o  = 1'b1;
            pend_d     = ce_good;
            wr_phase_d = 1'b1;
            state_d    = S_FIX;
          end
        end else begin
          advance = 1'b1;
        end
      end
      S_FIX: begin
        // Demand traffic may have rewritten the line; captured data is stale.
        if (busy_i) begin
          pend_d  = '0;
          state_d = S_READ;
        end else if (wr_phase_q) begin
          req_o = lowest;
          we_o  = 1'b1;
          if (gnt_i) begin
            pend_d   = pend_rest;
            ce_cnt_d = sat_add(ce_cnt_q, 8'd1);
            if (pend_rest == '0) state_d = S_VERIFY;
            else wr_phase_d = 1'b0;
          end
        end else begin
          req_o      = lowest;
          capture_o  = 1'b1;
          wr_phase_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      idx_d       = (idx_q == LastIdx) ? '0 : idx_q + IdxWidth'(1);
      pass_done_d = (idx_q == LastIdx);
      ue_seen_d   = '0;
      pend_d      = '0;
      if (!en_i) state_d = S_IDLE;
      else if (interval_i == '0) state_d = S_READ;
      else begin
        state_d = S_WAIT;
        cnt_d   = interval_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      ue_seen_q   <= '0;
      verifying_q <= 1'b0;
      wr_phase_q  <= 1'b0;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
      ue_idx_q    <= '0;
      ue_irq_q    <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ue_seen_q   <= ue_seen_d;
      verifying_q <= verifying_d;
      wr_phase_q  <= wr_phase_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
      ue_idx_q    <= ue_idx_d;
      ue_irq_q    <= ue_irq_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign idx_o       = idx_q;
  assign ce_cnt_o    = ce_cnt_q;
  assign ue_cnt_o    = ue_cnt_q;
  assign ue_idx_o    = ue_idx_q;
  assign ue_irq_o    = ue_irq_q;
  assign pass_done_o = pass_done_q;

endmodule
